// File: rtl/render_pkg.sv
// Shared constants for the column renderer and the slice-size calculator:
// screen geometry, colours, FSM encoding and the row colour helper.
package render_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COL_W    = 8;
  localparam int unsigned SLICE_W  = 7;
  localparam int unsigned ROW_W    = 7;

  localparam logic [2:0] CEIL_COLOUR  = 3'b001;
  localparam logic [2:0] WALL_COLOUR  = 3'b100;
  localparam logic [2:0] FLOOR_COLOUR = 3'b010;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAW  = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SCREEN_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SCREEN_H - 1);

  // Watchdog gives up on the 255th cycle spent waiting for the calculator.
  localparam logic [7:0] WD_LIMIT = 8'd254;

  function automatic logic [2:0] pixel_colour(input logic [7:0] row,
                                              input logic [7:0] top,
                                              input logic [7:0] bottom);
    if (row < top)         return CEIL_COLOUR;
    else if (row < bottom) return WALL_COLOUR;
    else                   return FLOOR_COLOUR;
  endfunction

endpackage

// File: rtl/slice_bounds.sv
// Vertical wall extent for one column: clamps the slice to the screen height
// and centres it, giving the first wall row (top) and the exclusive end row.
module slice_bounds
  import render_pkg::*;
(
  input  logic [SLICE_W-1:0] s,
  output logic [7:0]         top,
  output logic [7:0]         bottom
);

  logic [7:0] s_clamped;

  always_comb begin
    s_clamped = (8'(s) > 8'(SCREEN_H)) ? 8'(SCREEN_H) : 8'(s);
    top       = (8'(SCREEN_H) - s_clamped) >> 1;
    bottom    = top + s_clamped;
  end

endmodule

// File: rtl/render_columns.sv
// Frame scheduler: requests one slice per column, then plots the column as
// ceiling/wall/floor. Define RENDER_TIMEOUT_EN to add the calculator watchdog.
module render_columns
  import render_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic signed [12:0]  playerX_in,
  input  logic signed [12:0]  playerY_in,
  input  logic signed [9:0]   angle_X_in,
  input  logic signed [9:0]   angle_Y_in,
  output logic signed [12:0]  playerX,
  output logic signed [12:0]  playerY,
  output logic signed [9:0]   angle_X,
  output logic signed [9:0]   angle_Y,
  output logic [COL_W-1:0]    column_count,
  output logic                begin_calc,
  input  logic [SLICE_W-1:0]  slice_size,
  input  logic                end_calc,
  output logic [COL_W-1:0]    x,
  output logic [ROW_W-1:0]    y,
  output logic [2:0]          colour,
  output logic                plot,
  output logic                busy,
  output logic                frame_done
`ifdef RENDER_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  logic [2:0]         state;
  logic [SLICE_W-1:0] s_reg;
  logic [SLICE_W-1:0] s_sel;
  logic [7:0]         top;
  logic [7:0]         bottom;
  logic [7:0]         row_next;
  logic [2:0]         colour_next;
  logic               accept;
`ifdef RENDER_TIMEOUT_EN
  logic [7:0]         wd;
  logic               timed_out;
`endif

  // While waiting, bounds come straight from the incoming slice so the first
  // row's colour is ready on the accepting edge; afterwards from s_reg.
  always_comb begin
    s_sel       = s_reg;
    row_next    = 8'(y) + 8'd1;
    accept      = 1'b0;
`ifdef RENDER_TIMEOUT_EN
    timed_out   = (wd == WD_LIMIT) && !end_calc;
`endif
    if (state == S_WAIT) begin
      s_sel    = end_calc ? slice_size : '0;
      row_next = '0;
      accept   = end_calc;
`ifdef RENDER_TIMEOUT_EN
      accept   = end_calc || timed_out;
`endif
    end
    colour_next = pixel_colour(row_next, top, bottom);
  end

  slice_bounds u_bounds (
    .s      (s_sel),
    .top    (top),
    .bottom (bottom)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      s_reg        <= '0;
      playerX      <= '0;
      playerY      <= '0;
      angle_X      <= '0;
      angle_Y      <= '0;
      column_count <= '0;
      begin_calc   <= 1'b0;
      x            <= '0;
      y            <= '0;
      colour       <= '0;
      plot         <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
`ifdef RENDER_TIMEOUT_EN
      wd           <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      begin_calc <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (start) state <= S_LATCH;
        S_LATCH: begin
          playerX      <= playerX_in;
          playerY      <= playerY_in;
          angle_X      <= angle_X_in;
          angle_Y      <= angle_Y_in;
          column_count <= '0;
          busy         <= 1'b1;
          begin_calc   <= 1'b1;
          state        <= S_REQ;
        end
        S_REQ: begin
`ifdef RENDER_TIMEOUT_EN
          wd    <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (accept) begin
            s_reg  <= s_sel;
            x      <= column_count;
            y      <= '0;
            colour <= colour_next;
            plot   <= 1'b1;
            state  <= S_DRAW;
          end
`ifdef RENDER_TIMEOUT_EN
          if (timed_out) timeout_err <= 1'b1;
          wd <= wd + 8'd1;
`endif
        end
        S_DRAW: begin
          if (y == LAST_ROW) begin
            plot  <= 1'b0;
            state <= S_NEXT;
          end else begin
            y      <= y + 1'b1;
            colour <= colour_next;
          end
        end
        S_NEXT: begin
          if (column_count == LAST_COL) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            column_count <= column_count + 1'b1;
            begin_calc   <= 1'b1;
            state        <= S_REQ;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
